// File: rtl/dotted_call_sched.sv
// Round-robin scheduler sharing one callee among NREQ requesters, one call in flight at a time.
// A watchdog aborts calls whose result does not arrive within TIMEOUT WAIT cycles.
module dotted_call_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_arg,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data,
    output logic               rsp_err,
    output logic               call_valid,
    output logic [DW-1:0]      call_arg,
    input  logic               call_ready,
    input  logic               ret_valid,
    input  logic [DW-1:0]      ret_data,
    output logic               busy
);

    localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0]  TMAX = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e state_q, state_d;

    logic [PW-1:0]   rr_q, rr_d;
    logic [PW-1:0]   gnt_q, gnt_d;
    logic [7:0]      timer_q, timer_d;
    logic [NREQ-1:0] req_ready_q, req_ready_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;
    logic            call_valid_q, call_valid_d;
    logic [DW-1:0]   call_arg_q, call_arg_d;
    logic            busy_q, busy_d;

    logic [DW-1:0]   arg_arr [NREQ];
    logic            found;
    logic [PW-1:0]   pick;
    logic [NREQ-1:0] gnt_onehot;
    logic [PW-1:0]   gnt_next;

    for (genvar i = 0; i < NREQ; i++) begin : g_arg
        assign arg_arr[i] = req_arg[i*DW +: DW];
    end

    // First requesting index at or after rr_q, wrapping modulo NREQ.
    always_comb begin
        int unsigned sum;
        logic [PW-1:0] idx;
        found = 1'b0;
        pick  = '0;
        sum   = 0;
        idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            sum = 32'(rr_q) + k;
            idx = PW'(sum % NREQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign gnt_onehot = NREQ'(1) << gnt_q;
    assign gnt_next   = PW'((32'(gnt_q) + 32'd1) % NREQ);

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        gnt_d        = gnt_q;
        timer_d      = timer_q;
        req_ready_d  = '0;
        rsp_valid_d  = '0;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        call_valid_d = call_valid_q;
        call_arg_d   = call_arg_q;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    gnt_d        = pick;
                    call_arg_d   = arg_arr[pick];
                    call_valid_d = 1'b1;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                if (call_ready) begin
                    req_ready_d  = gnt_onehot;
                    call_valid_d = 1'b0;
                    timer_d      = '0;
                    state_d      = StWait;
                end
            end
            StWait: begin
                // A return on the final WAIT cycle beats the watchdog.
                if (ret_valid) begin
                    rsp_data_d  = ret_data;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = gnt_onehot;
                    state_d     = StResp;
                end else if (timer_q + 8'd1 == TMAX) begin
                    rsp_data_d  = '1;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = gnt_onehot;
                    state_d     = StResp;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            StResp: begin
                rr_d    = gnt_next;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            rr_q         <= '0;
            gnt_q        <= '0;
            timer_q      <= '0;
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            call_valid_q <= 1'b0;
            call_arg_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            gnt_q        <= gnt_d;
            timer_q      <= timer_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            call_valid_q <= call_valid_d;
            call_arg_q   <= call_arg_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign call_valid = call_valid_q;
    assign call_arg   = call_arg_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_dotted_call_sched.sv
// Directed and randomized bench for dotted_call_sched against a transaction-level model.
module tb_dotted_call_sched;

    localparam int NREQ    = 4;
    localparam int DW      = 32;
    localparam int TIMEOUT = 15;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    pend;
    logic [DW-1:0]      args [NREQ];
    logic [NREQ*DW-1:0] req_arg;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic               rsp_err;
    logic               call_valid;
    logic [DW-1:0]      call_arg;
    logic               call_ready;
    logic               ret_valid;
    logic [DW-1:0]      ret_data;
    logic               busy;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int rr_m   = 0;
    logic [NREQ-1:0] obs_rsp;

    always #5 clk = ~clk;

    for (genvar i = 0; i < NREQ; i++) begin : g_pack
        assign req_arg[i*DW +: DW] = args[i];
    end

    dotted_call_sched #(
        .NREQ    (NREQ),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (pend),
        .req_arg    (req_arg),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .call_valid (call_valid),
        .call_arg   (call_arg),
        .call_ready (call_ready),
        .ret_valid  (ret_valid),
        .ret_data   (ret_data),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: rotate the request mask so rr sits at bit 0, take the lowest set bit.
    function automatic int rr_pick(input logic [NREQ-1:0] m, input int ptr);
        logic [2*NREQ-1:0] dbl;
        dbl = {m, m} >> ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (dbl[i]) return (ptr + i) % NREQ;
        end
        return -1;
    endfunction

    // One complete call; ret_dly counts WAIT cycles before the return (>= TIMEOUT means never).
    task automatic do_call(input int rdy_dly, input int ret_dly, input logic [DW-1:0] rdata,
                           input bit stray);
        int g;
        int kr;
        int t0;
        bit err;
        logic [DW-1:0]   exp_data;
        logic [NREQ-1:0] oh;
        g  = rr_pick(pend, rr_m);
        oh = '0;
        oh[g] = 1'b1;
        err      = (ret_dly >= TIMEOUT);
        kr       = err ? TIMEOUT - 1 : ret_dly;
        exp_data = err ? '1 : rdata;

        chk("idle_busy", busy, 0);
        chk("idle_call_valid", call_valid, 0);
        t0 = cycle;
        tick();
        chk("issue_busy", busy, 1);
        for (int c = 0; c <= rdy_dly; c++) begin
            call_ready = (c == rdy_dly);
            ret_valid  = stray && (c == rdy_dly);
            ret_data   = $urandom;
            chk("issue_call_valid", call_valid, 1);
            chk("issue_call_arg", call_arg, args[g]);
            chk("issue_req_ready", req_ready, 0);
            tick();
        end
        call_ready = 1'b0;
        for (int k = 0; k <= kr; k++) begin
            ret_valid = (k == ret_dly);
            ret_data  = (k == ret_dly) ? rdata : $urandom;
            chk("wait_req_ready", req_ready, (k == 0) ? oh : '0);
            chk("wait_rsp_valid", rsp_valid, 0);
            chk("wait_call_valid", call_valid, 0);
            if (k == 0) pend[g] = 1'b0;
            tick();
        end
        ret_valid = 1'b0;
        obs_rsp = rsp_valid;
        chk("resp_rsp_valid", rsp_valid, oh);
        chk("resp_rsp_data", rsp_data, exp_data);
        chk("resp_rsp_err", rsp_err, err);
        chk("resp_latency", cycle - t0 + 1, 4 + rdy_dly + kr);
        tick();
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_rsp_data_hold", rsp_data, exp_data);
        chk("post_rsp_err_hold", rsp_err, err);
        rr_m = (g + 1) % NREQ;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst        = 1'b1;
        pend       = '0;
        call_ready = 1'b0;
        ret_valid  = 1'b0;
        ret_data   = '0;
        for (int i = 0; i < NREQ; i++) args[i] = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_call_valid", call_valid, 0);
        chk("rst_call_arg", call_arg, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // No requests: stays idle.
        tick();
        tick();
        chk("noreq_busy", busy, 0);
        chk("noreq_call_valid", call_valid, 0);

        // Single call from requester 1.
        args[1] = 32'h0000_0001;
        pend    = 4'b0010;
        do_call(0, 2, 32'h6d62_2020, 1'b0);

        // Backpressure: call_ready low for 5 ISSUE cycles.
        args[2] = 32'hcafe_0002;
        pend    = 4'b0100;
        do_call(5, 0, 32'h0000_abcd, 1'b0);

        // Timeout, then a stray return in IDLE.
        args[0] = 32'h1111_0000;
        pend    = 4'b0001;
        do_call(0, 1000, 32'h0, 1'b0);
        ret_valid = 1'b1;
        ret_data  = 32'h1234_5678;
        tick();
        ret_valid = 1'b0;
        chk("stray_rsp_valid", rsp_valid, 0);
        chk("stray_busy", busy, 0);
        tick();
        chk("stray_rsp_data", rsp_data, 32'hffff_ffff);
        chk("stray_rsp_err", rsp_err, 1);
        chk("stray_call_valid", call_valid, 0);

        // Return on the exact timeout cycle wins.
        args[3] = 32'h3333_3333;
        pend    = 4'b1000;
        do_call(0, TIMEOUT - 1, 32'h0000_f00d, 1'b1);

        // Reset while in WAIT.
        args[2] = 32'h2222_2222;
        pend    = 4'b0100;
        tick();
        call_ready = 1'b1;
        tick();
        call_ready = 1'b0;
        pend       = '0;
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_req_ready", req_ready, 0);
        chk("midrst_call_valid", call_valid, 0);
        chk("midrst_rsp_data", rsp_data, 0);
        tick();
        rst  = 1'b0;
        rr_m = 0;
        tick();
        ret_valid = 1'b1;
        ret_data  = 32'h0000_f22d;
        tick();
        ret_valid = 1'b0;
        chk("midrst_late_rsp_valid", rsp_valid, 0);
        chk("midrst_late_busy", busy, 0);
        tick();
        chk("midrst_late_rsp_data", rsp_data, 0);

        // Round-robin with every requester asserting: grants 0,1,2,3,0.
        for (int n = 0; n < 5; n++) begin
            pend = '1;
            for (int i = 0; i < NREQ; i++) args[i] = $urandom;
            do_call(0, 0, $urandom, 1'b0);
            chk("rr_order", obs_rsp, 4'b0001 << (n % NREQ));
        end

        // Randomized calls.
        for (int n = 0; n < 24; n++) begin
            pend = 4'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) args[i] = $urandom;
            do_call($urandom_range(0, 3), $urandom_range(0, 17), $urandom, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
